bfly2_tw_pipe: RTL and testbench
================================

BFLY2_TW_PIPE -- requirements
Module: bfly2_tw_pipe

Interface
REQ-001 SHALL have parameter SIG, default 1, sign bits of input samples.
REQ-002 SHALL have parameter INT, default 3, integer bits of input samples.
REQ-003 SHALL have parameter FLT, default 6, fractional bits of input samples; WIDTH = SIG+INT+FLT (local).
REQ-004 SHALL have parameter TW_FLT, default 8, twiddle fractional bits; TW_W = TW_FLT+2 (local, signed 1.TW_FLT format plus sign).
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1, input beat present.
REQ-008 SHALL have port in_ready, output, 1, block accepts input beat this cycle.
REQ-009 SHALL have ports din1_re, din1_im, din2_re, din2_im, input, signed WIDTH, butterfly operands.
REQ-010 SHALL have ports tw_re, tw_im, input, signed TW_W, twiddle applied to the difference leg.
REQ-011 SHALL have port scale_en, input, 1, per-beat divide-by-2 mode, captured with the beat.
REQ-012 SHALL have port out_valid, output, 1, output beat present.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts output beat.
REQ-014 SHALL have ports dout1_re, dout1_im, dout2_re, dout2_im, output, signed WIDTH+1, butterfly results.
REQ-015 SHALL have port ovf, output, 1, saturation occurred on the current output beat.
REQ-016 SHALL have port ovf_sticky, output, 1, saturation occurred since reset or clear.
REQ-017 SHALL have port ovf_clr, input, 1, synchronous clear of ovf_sticky.

Function
REQ-018 SHALL be a 3-stage pipeline: S1 sum/difference, S2 complex multiply, S3 round/scale/saturate; latency exactly 3 cycles with out_ready held high.
REQ-019 S1 SHALL compute sum = din1+din2 and diff = din1-din2 per component at WIDTH+1 bits, no overflow possible.
REQ-020 S2 SHALL compute p_re = diff_re*tw_re - diff_im*tw_im and p_im = diff_re*tw_im + diff_im*tw_re at full precision (WIDTH+TW_W+2 bits).
REQ-021 S3 SHALL set s = TW_FLT + scale_en and dout2 = (p + 2^(s-1)) >>> s (round half up), then saturate to signed WIDTH+1 range.
REQ-022 S3 SHALL set dout1 = sum when scale_en=0, (sum+1) >>> 1 when scale_en=1; dout1 never saturates.
REQ-023 ovf SHALL be 1 iff either dout2 component saturated on the presented beat, qualified by out_valid.
REQ-024 ovf_sticky SHALL set on any accepted beat (out_valid and out_ready) with ovf=1; ovf_clr clears it; simultaneous set and clear yields 1.
REQ-025 Pipeline SHALL advance when out_ready=1 or out_valid=0; in_ready SHALL equal that advance condition (combinational from out_ready).
REQ-026 A beat SHALL transfer on input when in_valid and in_ready, on output when out_valid and out_ready.
REQ-027 When stalled, all stage registers, per-stage valid bits and scale_en tags SHALL hold; outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 Beats SHALL emerge in acceptance order; none dropped or duplicated; bubbles SHALL propagate as valid=0.
REQ-029 Each beat SHALL carry its own scale_en through all stages; mixed-mode streams SHALL be processed per beat.

Reset
REQ-030 On rst_n low, all valid bits, out_valid, ovf and ovf_sticky SHALL go to 0 immediately; data outputs SHALL be 0.
REQ-031 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-032 Reset mid-stream SHALL discard all in-flight beats; first beat after release appears 3 cycles after acceptance.

Verification
REQ-033 din1=(100,0), din2=(50,0), tw=(256,0), scale_en=0 -> 3 cycles later dout1=(150,0), dout2=(50,0), ovf=0.
REQ-034 din1=(50,0), din2=(0,0), tw=(0,-256) -> dout1=(50,0), dout2=(0,-50).
REQ-035 din1=(511,511), din2=(-512,-512), tw=(256,256) -> dout2=(0,1023), ovf=1, ovf_sticky=1 until ovf_clr pulse.
REQ-036 din1=(3,0), din2=(0,0), tw=(256,0), scale_en=1 -> dout1=(2,0), dout2=(2,0).
REQ-037 Stream 6 back-to-back beats, hold out_ready=0 for 4 cycles mid-stream -> in_ready low while full, 6 outputs in order, outputs stable during stall.
REQ-038 Assert rst_n low with 3 beats in flight -> out_valid=0 immediately, no stale beat after release.

Source files
------------

// File: rtl/bfly2_tw_pipe_if.sv
// Streaming port bundle for the radix-2 twiddle butterfly: input beat, output beat and overflow status.
// The DUT connects through the slave modport; the producer/consumer side uses master.
interface bfly2_tw_pipe_if #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned TW_W  = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] din1_re;
    logic signed [WIDTH-1:0] din1_im;
    logic signed [WIDTH-1:0] din2_re;
    logic signed [WIDTH-1:0] din2_im;
    logic signed [TW_W-1:0]  tw_re;
    logic signed [TW_W-1:0]  tw_im;
    logic                    scale_en;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH:0]   dout1_re;
    logic signed [WIDTH:0]   dout1_im;
    logic signed [WIDTH:0]   dout2_re;
    logic signed [WIDTH:0]   dout2_im;
    logic                    ovf;
    logic                    ovf_sticky;
    logic                    ovf_clr;

    modport master (
        output in_valid, din1_re, din1_im, din2_re, din2_im, tw_re, tw_im, scale_en,
        output out_ready, ovf_clr,
        input  in_ready, out_valid, dout1_re, dout1_im, dout2_re, dout2_im, ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, din1_re, din1_im, din2_re, din2_im, tw_re, tw_im, scale_en,
        input  out_ready, ovf_clr,
        output in_ready, out_valid, dout1_re, dout1_im, dout2_re, dout2_im, ovf, ovf_sticky
    );
endinterface

// File: rtl/bfly2_tw_pipe.sv
// Three-stage radix-2 butterfly with twiddle on the difference leg: add/sub, complex multiply,
// then round, optional per-beat halving and saturation. Whole pipeline stalls on output backpressure.
module bfly2_tw_pipe #(
    parameter int unsigned SIG    = 1,
    parameter int unsigned INT    = 3,
    parameter int unsigned FLT    = 6,
    parameter int unsigned TW_FLT = 8
) (
    input logic            clk,
    input logic            rst_n,
    bfly2_tw_pipe_if.slave io
);
    localparam int unsigned WIDTH = SIG + INT + FLT;
    localparam int unsigned TW_W  = TW_FLT + 2;
    localparam int unsigned OW    = WIDTH + 1;
    localparam int unsigned OW1   = OW + 1;
    localparam int unsigned PW    = WIDTH + TW_W + 2;
    localparam int unsigned RW    = PW + 1;

    localparam logic signed [RW-1:0] OMAX  = (RW'(1) <<< (OW - 1)) - RW'(1);
    localparam logic signed [RW-1:0] OMIN  = -(RW'(1) <<< (OW - 1));
    localparam logic signed [RW-1:0] HALF0 = RW'(1) <<< (TW_FLT - 1);
    localparam logic signed [RW-1:0] HALF1 = RW'(1) <<< TW_FLT;

    // Round half up by TW_FLT (+1 when halving), then clamp; MSB of result flags saturation.
    function automatic logic [OW:0] rnd_sat(input logic signed [PW-1:0] p, input logic sc);
        logic signed [RW-1:0] r;
        if (sc) r = (RW'(p) + HALF1) >>> (TW_FLT + 1);
        else    r = (RW'(p) + HALF0) >>> TW_FLT;
        if (r > OMAX)      rnd_sat = {1'b1, OMAX[OW-1:0]};
        else if (r < OMIN) rnd_sat = {1'b1, OMIN[OW-1:0]};
        else               rnd_sat = {1'b0, r[OW-1:0]};
    endfunction

    function automatic logic signed [OW-1:0] half_sum(input logic signed [OW-1:0] s, input logic sc);
        logic signed [OW:0] t;
        t = OW1'(s) + OW1'(1);
        half_sum = sc ? OW'(t >>> 1) : s;
    endfunction

    logic adv;

    logic                 v1, sc1;
    logic signed [OW-1:0] sum_re1, sum_im1, dif_re1, dif_im1;
    logic signed [TW_W-1:0] twr1, twi1;

    logic                 v2, sc2;
    logic signed [OW-1:0] sum_re2, sum_im2;
    logic signed [PW-1:0] p_re2, p_im2;

    logic                 v3, ovf3, sticky;
    logic signed [OW-1:0] d1re3, d1im3, d2re3, d2im3;

    logic [OW:0] r_re_c, r_im_c;

    // A single advance enable moves every stage together; a full output stalls everything.
    assign adv         = io.out_ready | ~v3;
    assign io.in_ready = adv;

    // S1: sum and difference legs, twiddle and mode captured alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            sc1     <= 1'b0;
            sum_re1 <= '0;
            sum_im1 <= '0;
            dif_re1 <= '0;
            dif_im1 <= '0;
            twr1    <= '0;
            twi1    <= '0;
        end else if (adv) begin
            v1      <= io.in_valid;
            sc1     <= io.scale_en;
            sum_re1 <= OW'(io.din1_re) + OW'(io.din2_re);
            sum_im1 <= OW'(io.din1_im) + OW'(io.din2_im);
            dif_re1 <= OW'(io.din1_re) - OW'(io.din2_re);
            dif_im1 <= OW'(io.din1_im) - OW'(io.din2_im);
            twr1    <= io.tw_re;
            twi1    <= io.tw_im;
        end
    end

    // S2: full-precision complex multiply of the difference leg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            sc2     <= 1'b0;
            sum_re2 <= '0;
            sum_im2 <= '0;
            p_re2   <= '0;
            p_im2   <= '0;
        end else if (adv) begin
            v2      <= v1;
            sc2     <= sc1;
            sum_re2 <= sum_re1;
            sum_im2 <= sum_im1;
            p_re2   <= PW'(dif_re1) * PW'(twr1) - PW'(dif_im1) * PW'(twi1);
            p_im2   <= PW'(dif_re1) * PW'(twi1) + PW'(dif_im1) * PW'(twr1);
        end
    end

    assign r_re_c = rnd_sat(p_re2, sc2);
    assign r_im_c = rnd_sat(p_im2, sc2);

    // S3: rounded/scaled results; ovf only ever set together with a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            ovf3  <= 1'b0;
            d1re3 <= '0;
            d1im3 <= '0;
            d2re3 <= '0;
            d2im3 <= '0;
        end else if (adv) begin
            v3    <= v2;
            ovf3  <= v2 & (r_re_c[OW] | r_im_c[OW]);
            d1re3 <= half_sum(sum_re2, sc2);
            d1im3 <= half_sum(sum_im2, sc2);
            d2re3 <= r_re_c[OW-1:0];
            d2im3 <= r_im_c[OW-1:0];
        end
    end

    // Sticky flag: a set on an accepted beat wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky <= 1'b0;
        else        sticky <= (v3 & io.out_ready & ovf3) | (sticky & ~io.ovf_clr);
    end

    assign io.out_valid  = v3;
    assign io.ovf        = ovf3;
    assign io.ovf_sticky = sticky;
    assign io.dout1_re   = d1re3;
    assign io.dout1_im   = d1im3;
    assign io.dout2_re   = d2re3;
    assign io.dout2_im   = d2im3;
endmodule

// File: tb/tb_bfly2_tw_pipe.sv
// Bench for bfly2_tw_pipe: directed corner beats plus randomized traffic with backpressure,
// checked against an arithmetic reference queue tracking how far each beat has travelled.
module tb_bfly2_tw_pipe;
    localparam int unsigned SIG    = 1;
    localparam int unsigned INT    = 3;
    localparam int unsigned FLT    = 6;
    localparam int unsigned TW_FLT = 8;
    localparam int unsigned WIDTH  = SIG + INT + FLT;
    localparam int unsigned TW_W   = TW_FLT + 2;
    localparam int unsigned OW     = WIDTH + 1;

    typedef struct {
        longint o1r, o1i, o2r, o2i;
        bit     ovf;
        int     age;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    bit   sticky_m;
    bit   last_acc;
    int   n_cmp, n_bad;
    int   n_acc, n_dut_out;

    bfly2_tw_pipe_if #(.WIDTH(WIDTH), .TW_W(TW_W)) io ();

    bfly2_tw_pipe #(.SIG(SIG), .INT(INT), .FLT(FLT), .TW_FLT(TW_FLT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint rnd_sat(longint p, bit sc, output bit sat);
        longint s, r, lim;
        s   = longint'(TW_FLT) + longint'(sc);
        r   = (p + (longint'(1) << (s - 1))) >>> s;
        lim = longint'(1) << (OW - 1);
        sat = 1'b1;
        if (r > lim - 1)   return lim - 1;
        if (r < -lim)      return -lim;
        sat = 1'b0;
        return r;
    endfunction

    function automatic exp_t ref_beat(longint ar, longint ai, longint br, longint bi,
                                      longint wr, longint wi, bit sc);
        exp_t   e;
        longint sr, si, dr, di;
        bit     s_re, s_im;
        sr    = ar + br;
        si    = ai + bi;
        dr    = ar - br;
        di    = ai - bi;
        e.o1r = sc ? (sr + 1) >>> 1 : sr;
        e.o1i = sc ? (si + 1) >>> 1 : si;
        e.o2r = rnd_sat(dr * wr - di * wi, sc, s_re);
        e.o2i = rnd_sat(dr * wi + di * wr, sc, s_im);
        e.ovf = s_re | s_im;
        e.age = 1;
        return e;
    endfunction

    task automatic drive(bit v, int ar, int ai, int br, int bi, int wr, int wi, bit sc);
        io.in_valid = v;
        io.din1_re  = WIDTH'(ar);
        io.din1_im  = WIDTH'(ai);
        io.din2_re  = WIDTH'(br);
        io.din2_im  = WIDTH'(bi);
        io.tw_re    = TW_W'(wr);
        io.tw_im    = TW_W'(wi);
        io.scale_en = sc;
    endtask

    // One clock: check at the falling edge, advance the reference, return just after the rising edge.
    task automatic step();
        bit ev, eir, set;
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            sticky_m = 1'b0;
        end
        ev  = (q.size() > 0) && (q[0].age >= 3);
        eir = io.out_ready || !ev;
        check("out_valid", io.out_valid, ev);
        check("in_ready", io.in_ready, eir);
        check("ovf", io.ovf, ev ? q[0].ovf : 1'b0);
        check("ovf_sticky", io.ovf_sticky, sticky_m);
        if (ev) begin
            check("dout1_re", io.dout1_re, q[0].o1r);
            check("dout1_im", io.dout1_im, q[0].o1i);
            check("dout2_re", io.dout2_re, q[0].o2r);
            check("dout2_im", io.dout2_im, q[0].o2i);
        end
        if (io.out_valid && io.out_ready && rst_n) n_dut_out++;
        last_acc = 1'b0;
        set      = 1'b0;
        if (rst_n) begin
            if (eir) begin
                if (ev && io.out_ready) begin
                    set = q[0].ovf;
                    void'(q.pop_front());
                end
                for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
                if (io.in_valid) begin
                    q.push_back(ref_beat(longint'(io.din1_re), longint'(io.din1_im),
                                         longint'(io.din2_re), longint'(io.din2_im),
                                         longint'(io.tw_re), longint'(io.tw_im), io.scale_en));
                    last_acc = 1'b1;
                    n_acc++;
                end
            end
            sticky_m = set || (sticky_m && !io.ovf_clr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(int ar, int ai, int br, int bi, int wr, int wi, bit sc);
        drive(1'b1, ar, ai, br, bi, wr, wi, sc);
        step();
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        step();
        step();
    endtask

    function automatic int rnd_s(int w);
        case ($urandom_range(0, 7))
            0:       return (1 << (w - 1)) - 1;
            1:       return -(1 << (w - 1));
            default: return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
        endcase
    endfunction

    initial begin
        int idx, cyc, acc0, out0;
        clk = 1'b0;
        rst_n = 1'b0;
        n_cmp = 0; n_bad = 0; n_acc = 0; n_dut_out = 0;
        sticky_m = 1'b0;
        io.out_ready = 1'b1;
        io.ovf_clr   = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        #3;
        check("rst_out_valid", io.out_valid, 0);
        check("rst_in_ready", io.in_ready, 1);
        check("rst_ovf", io.ovf, 0);
        check("rst_sticky", io.ovf_sticky, 0);
        check("rst_dout1_re", io.dout1_re, 0);
        check("rst_dout2_im", io.dout2_im, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Reference beats with known results, 3 cycles after acceptance.
        send(100, 0, 50, 0, 256, 0, 1'b0);
        check("d33_valid", io.out_valid, 1);
        check("d33_d1re", io.dout1_re, 150);
        check("d33_d1im", io.dout1_im, 0);
        check("d33_d2re", io.dout2_re, 50);
        check("d33_d2im", io.dout2_im, 0);
        check("d33_ovf", io.ovf, 0);
        step();
        send(50, 0, 0, 0, 0, -256, 1'b0);
        check("d34_d1re", io.dout1_re, 50);
        check("d34_d2re", io.dout2_re, 0);
        check("d34_d2im", io.dout2_im, -50);
        step();
        send(3, 0, 0, 0, 256, 0, 1'b1);
        check("d36_d1re", io.dout1_re, 2);
        check("d36_d2re", io.dout2_re, 2);
        step();
        send(511, 511, -512, -512, 256, 256, 1'b0);
        check("d35_d2re", io.dout2_re, 0);
        check("d35_d2im", io.dout2_im, 1023);
        check("d35_ovf", io.ovf, 1);
        step();
        check("d35_sticky_set", io.ovf_sticky, 1);
        check("d35_ovf_after", io.ovf, 0);
        step(); step(); step();
        check("d35_sticky_hold", io.ovf_sticky, 1);
        io.ovf_clr = 1'b1;
        step();
        io.ovf_clr = 1'b0;
        check("d35_sticky_clr", io.ovf_sticky, 0);
        // Clear coinciding with a saturating accepted beat leaves the flag set.
        send(-512, 0, 511, 0, 511, 0, 1'b0);
        io.ovf_clr = 1'b1;
        step();
        io.ovf_clr = 1'b0;
        check("setclr_sticky", io.ovf_sticky, 1);
        io.ovf_clr = 1'b1;
        step();
        io.ovf_clr = 1'b0;

        // Six back-to-back beats with a 4-cycle output stall in the middle.
        out0 = n_dut_out;
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 100) begin
            drive(1'b1, rnd_s(WIDTH), rnd_s(WIDTH), rnd_s(WIDTH), rnd_s(WIDTH),
                  rnd_s(TW_W), rnd_s(TW_W), 1'($urandom_range(0, 1)));
            io.out_ready = !(cyc >= 4 && cyc < 8);
            step();
            if (last_acc) idx++;
            cyc++;
        end
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        io.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("stall_beats_out", n_dut_out - out0, 6);

        // Randomized traffic with backpressure and occasional sticky clears.
        acc0 = n_acc;
        out0 = n_dut_out;
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rnd_s(WIDTH), rnd_s(WIDTH), rnd_s(WIDTH),
                  rnd_s(WIDTH), rnd_s(TW_W), rnd_s(TW_W), 1'($urandom_range(0, 1)));
            io.out_ready = ($urandom_range(0, 9) < 7);
            io.ovf_clr   = ($urandom_range(0, 15) == 0);
            step();
        end
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        io.out_ready = 1'b1;
        io.ovf_clr   = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("rand_beat_count", n_dut_out - out0, n_acc - acc0);

        // Reset with three beats in flight: everything discarded at once.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd_s(WIDTH), rnd_s(WIDTH), rnd_s(WIDTH), rnd_s(WIDTH),
                  rnd_s(TW_W), rnd_s(TW_W), 1'b0);
            step();
        end
        drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
        check("pre_rst_valid", io.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", io.out_valid, 0);
        check("midrst_in_ready", io.in_ready, 1);
        check("midrst_sticky", io.ovf_sticky, 0);
        check("midrst_dout1_re", io.dout1_re, 0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        send(100, 0, 50, 0, 256, 0, 1'b0);
        check("postrst_valid", io.out_valid, 1);
        check("postrst_d1re", io.dout1_re, 150);
        check("postrst_d2re", io.dout2_re, 50);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
